// File: rtl/seal_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : seal_trace_buffer
// Description : Captures SEAL execution-probe records (op, A, B, result) into
//               an on-chip FIFO. The FIFO is drained over a simple 1 kB bus
//               slave. A level interrupt is raised when the fill level reaches
//               a programmable threshold.
// Revision    : 1.0 - initial release
// ============================================================================
module seal_trace_buffer #(
   parameter int Depth     = 16,
   parameter int DataWidth = 32,
   parameter int AddrWidth = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_i,
   input  logic                 we_i,
   input  logic [3:0]           be_i,
   input  logic [AddrWidth-1:0] addr_i,
   input  logic [DataWidth-1:0] wdata_i,
   output logic                 rvalid_o,
   output logic [DataWidth-1:0] rdata_o,
   output logic                 err_o,
   input  logic                 trace_valid_i,
   input  logic [6:0]           trace_op_i,
   input  logic [31:0]          trace_a_i,
   input  logic [31:0]          trace_b_i,
   input  logic [31:0]          trace_result_i,
   output logic                 irq_o
);

   localparam int PW = $clog2(Depth);
   localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

   // Register word indices (byte offset / 4)
   localparam logic [7:0] W_CTRL   = 8'h00;
   localparam logic [7:0] W_STATUS = 8'h01;
   localparam logic [7:0] W_THRESH = 8'h02;
   localparam logic [7:0] W_DROPS  = 8'h03;
   localparam logic [7:0] W_HEAD0  = 8'h04;
   localparam logic [7:0] W_HEAD1  = 8'h05;
   localparam logic [7:0] W_HEAD2  = 8'h06;
   localparam logic [7:0] W_HEAD3  = 8'h07;
   localparam logic [7:0] W_POP    = 8'h08;

   // Control / status state
   logic        en;
   logic        irq_en;
   logic [15:0] thresh;
   logic [31:0] drops;
   logic        ovf;

   // FIFO pointers carry one extra wrap bit so full and empty are distinct
   logic [PW:0]   wr_ptr;
   logic [PW:0]   rd_ptr;
   logic [PW:0]   count;
   logic [PW-1:0] rd_idx;
   logic [PW-1:0] wr_idx;
   logic          empty;
   logic          full;

   // Record storage, one array per record word
   logic [6:0]  mem_op  [Depth];
   logic [31:0] mem_a   [Depth];
   logic [31:0] mem_b   [Depth];
   logic [31:0] mem_res [Depth];

   // Bus decode and FIFO control strobes
   logic [7:0]  word;
   logic        wr_ok;
   logic        ctrl_wr;
   logic        thresh_wr;
   logic        pop_wr;
   logic        clear;
   logic        do_pop;
   logic        push_req;
   logic        do_push;
   logic        drop;
   logic [31:0] rd_data;
   logic        rd_err;

   // Address bits outside [9:2] and upper write-data bits carry no meaning
   logic unused_bits;
   assign unused_bits = ^{addr_i[AddrWidth-1:10], addr_i[1:0], wdata_i[DataWidth-1:16]};

   assign word   = addr_i[9:2];
   assign count  = wr_ptr - rd_ptr;
   assign rd_idx = rd_ptr[PW-1:0];
   assign wr_idx = wr_ptr[PW-1:0];
   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_idx == rd_idx);

   // Decode bus writes and resolve push/pop/drop for this cycle
   always_comb begin
      wr_ok     = req_i && we_i && (be_i == 4'hF);
      ctrl_wr   = wr_ok && (word == W_CTRL);
      thresh_wr = wr_ok && (word == W_THRESH);
      pop_wr    = wr_ok && (word == W_POP);
      clear     = ctrl_wr && wdata_i[2];
      do_pop    = pop_wr && !empty && !clear;
      push_req  = trace_valid_i && en;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts
      do_push   = push_req && (!full || pop_wr) && !clear;
      drop      = push_req && full && !pop_wr && !clear;
   end

   // Control registers, pointers and overflow bookkeeping
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         en     <= 1'b0;
         irq_en <= 1'b0;
         thresh <= 16'd0;
         drops  <= 32'd0;
         ovf    <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (ctrl_wr) begin
            en     <= wdata_i[0];
            irq_en <= wdata_i[1];
         end
         if (thresh_wr) begin
            thresh <= wdata_i[15:0];
         end
         if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
            drops  <= 32'd0;
         end else begin
            if (do_pop) begin
               rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push) begin
               wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (drop) begin
               ovf <= 1'b1;
               if (drops != 32'hFFFF_FFFF) begin
                  drops <= drops + 32'd1;
               end
            end
         end
      end
   end

   // Record storage write; contents only become visible through the pointers
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_op[wr_idx]  <= trace_op_i;
         mem_a[wr_idx]   <= trace_a_i;
         mem_b[wr_idx]   <= trace_b_i;
         mem_res[wr_idx] <= trace_result_i;
      end
   end

   // Register read mux and access-error classification
   always_comb begin
      rd_data = 32'd0;
      rd_err  = 1'b0;
      case (word)
         W_CTRL:   rd_data = {30'd0, irq_en, en};
         W_STATUS: begin
            rd_data = {13'd0, ovf, full, empty, 16'(count)};
            rd_err  = we_i;
         end
         W_THRESH: rd_data = {16'd0, thresh};
         W_DROPS: begin
            rd_data = drops;
            rd_err  = we_i;
         end
         W_HEAD0: begin
            rd_data = empty ? 32'd0 : {25'd0, mem_op[rd_idx]};
            rd_err  = we_i;
         end
         W_HEAD1: begin
            rd_data = empty ? 32'd0 : mem_a[rd_idx];
            rd_err  = we_i;
         end
         W_HEAD2: begin
            rd_data = empty ? 32'd0 : mem_b[rd_idx];
            rd_err  = we_i;
         end
         W_HEAD3: begin
            rd_data = empty ? 32'd0 : mem_res[rd_idx];
            rd_err  = we_i;
         end
         W_POP:    rd_err = !we_i;
         default:  rd_err = 1'b1;
      endcase
   end

   // Registered bus response, one cycle after the request
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_o <= 1'b0;
         rdata_o  <= '0;
         err_o    <= 1'b0;
      end else begin
         rvalid_o <= req_i;
         if (req_i) begin
            rdata_o <= (we_i || rd_err) ? '0 : rd_data;
            err_o   <= rd_err;
         end else begin
            rdata_o <= '0;
            err_o   <= 1'b0;
         end
      end
   end

   assign irq_o = en && irq_en && (thresh != 16'd0) && (16'(count) >= thresh);

endmodule
`default_nettype wire

// File: tb/tb_seal_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_seal_trace_buffer
// Description : Self-checking bench for seal_trace_buffer: constant vector
//               table, directed corner sequences, and randomized traffic
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seal_trace_buffer;

   localparam int DEPTH = 16;

   typedef struct {
      logic [6:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
   } rec_t;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          tv;
      rec_t        rec;
      logic [31:0] exp_rdata;
      bit          exp_err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;
   logic        trace_valid;
   logic [6:0]  trace_op;
   logic [31:0] trace_a;
   logic [31:0] trace_b;
   logic [31:0] trace_result;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   rec_t        q[$];
   bit          m_en, m_irq_en, m_ovf;
   logic [15:0] m_thresh;
   logic [31:0] m_drops;

   // Last cycle: sampled DUT outputs and model expectations
   logic [31:0] s_rdata, e_rdata;
   bit          s_err, s_rvalid, s_irq, e_err, e_irq;
   bit          l_rq, l_we;

   seal_trace_buffer #(.Depth(DEPTH), .DataWidth(32), .AddrWidth(32)) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .be_i(be),
      .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata),
      .err_o(err), .trace_valid_i(trace_valid), .trace_op_i(trace_op),
      .trace_a_i(trace_a), .trace_b_i(trace_b), .trace_result_i(trace_result),
      .irq_o(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   function automatic rec_t mk_rec(input logic [6:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] r);
      rec_t t;
      t.op = op; t.a = a; t.b = b; t.r = r;
      return t;
   endfunction

   task automatic model_reset();
      q.delete();
      m_en = 0; m_irq_en = 0; m_ovf = 0; m_thresh = 16'd0; m_drops = 32'd0;
   endtask

   // Expected bus response from the register map applied to the pre-cycle state
   task automatic model_resp(input logic [31:0] ad, input bit w,
                             output logic [31:0] rd, output bit er);
      logic [7:0] wd_idx;
      int n;
      wd_idx = ad[9:2];
      n = q.size();
      rd = 32'd0;
      er = 0;
      case (wd_idx)
         8'h00: rd = {30'd0, m_irq_en, m_en};
         8'h01: begin rd = {13'd0, m_ovf, (n == DEPTH), (n == 0), 16'(n)}; er = w; end
         8'h02: rd = {16'd0, m_thresh};
         8'h03: begin rd = m_drops; er = w; end
         8'h04: begin rd = (n > 0) ? {25'd0, q[0].op} : 32'd0; er = w; end
         8'h05: begin rd = (n > 0) ? q[0].a : 32'd0; er = w; end
         8'h06: begin rd = (n > 0) ? q[0].b : 32'd0; er = w; end
         8'h07: begin rd = (n > 0) ? q[0].r : 32'd0; er = w; end
         8'h08: er = !w;
         default: er = 1;
      endcase
      if (er) rd = 32'd0;
   endtask

   task automatic model_update(input bit rq, input bit w, input logic [31:0] ad,
                               input logic [31:0] wd, input logic [3:0] bb,
                               input bit tv, input rec_t rc);
      bit wr_ok;
      logic [7:0] wd_idx;
      bit old_en;
      wd_idx = ad[9:2];
      wr_ok  = rq && w && (bb == 4'hF);
      old_en = m_en;
      if (wr_ok && wd_idx == 8'h00 && wd[2]) begin
         q.delete();
         m_ovf = 0;
         m_drops = 32'd0;
      end else begin
         if (wr_ok && wd_idx == 8'h08 && q.size() > 0) void'(q.pop_front());
         if (tv && old_en) begin
            if (q.size() < DEPTH) q.push_back(rc);
            else begin
               m_ovf = 1;
               if (m_drops != 32'hFFFF_FFFF) m_drops = m_drops + 1;
            end
         end
      end
      if (wr_ok && wd_idx == 8'h00) begin m_en = wd[0]; m_irq_en = wd[1]; end
      if (wr_ok && wd_idx == 8'h02) m_thresh = wd[15:0];
      e_irq = m_en && m_irq_en && (m_thresh != 0) && (q.size() >= int'(m_thresh));
   endtask

   // One clock cycle: drive inputs, advance the model, sample the DUT after the edge
   task automatic do_cycle(input bit rq, input bit w, input logic [31:0] ad,
                           input logic [31:0] wd, input logic [3:0] bb,
                           input bit tv, input rec_t rc);
      req = rq; we = w; addr = ad; wdata = wd; be = bb;
      trace_valid = tv; trace_op = rc.op; trace_a = rc.a; trace_b = rc.b; trace_result = rc.r;
      l_rq = rq; l_we = w;
      model_resp(ad, w, e_rdata, e_err);
      if (!rq) begin e_rdata = 32'd0; e_err = 0; end
      model_update(rq, w, ad, wd, bb, tv, rc);
      @(posedge clk);
      #1;
      s_rdata = rdata; s_err = err; s_rvalid = rvalid; s_irq = irq;
      req = 0; we = 0; trace_valid = 0;
   endtask

   task automatic model_check(input string tag);
      chk({tag, "_rvalid"}, 32'(s_rvalid), 32'(l_rq));
      if (l_rq && !l_we) chk({tag, "_rdata"}, s_rdata, e_rdata);
      if (l_rq) chk({tag, "_err"}, 32'(s_err), 32'(e_err));
      chk({tag, "_irq"}, 32'(s_irq), 32'(e_irq));
   endtask

   task automatic rd(input logic [31:0] ad);
      do_cycle(1, 0, ad, 32'd0, 4'hF, 0, mk_rec(0, 0, 0, 0));
   endtask

   task automatic wr(input logic [31:0] ad, input logic [31:0] wd);
      do_cycle(1, 1, ad, wd, 4'hF, 0, mk_rec(0, 0, 0, 0));
   endtask

   task automatic push(input rec_t rc);
      do_cycle(0, 0, 32'd0, 32'd0, 4'hF, 1, rc);
   endtask

   vec_t vt[16];
   logic [9:0] offs[10];

   initial begin
      rec_t z;
      rec_t nr;
      z = mk_rec(0, 0, 0, 0);
      req = 0; we = 0; be = 4'hF; addr = 0; wdata = 0;
      trace_valid = 0; trace_op = 0; trace_a = 0; trace_b = 0; trace_result = 0;

      // Constant vectors starting from reset
      vt[0]  = '{0, 32'h04, 32'h0, 0, z, 32'h0001_0000, 0};
      vt[1]  = '{0, 32'h10, 32'h0, 0, z, 32'h0, 0};
      vt[2]  = '{1, 32'h00, 32'h1, 0, z, 32'h0, 0};
      vt[3]  = '{0, 32'h04, 32'h0, 1, mk_rec(7'h05, 1, 2, 3), 32'h0001_0000, 0};
      vt[4]  = '{0, 32'h04, 32'h0, 0, z, 32'h0000_0001, 0};
      vt[5]  = '{0, 32'h10, 32'h0, 0, z, 32'h5, 0};
      vt[6]  = '{0, 32'h14, 32'h0, 0, z, 32'h1, 0};
      vt[7]  = '{0, 32'h18, 32'h0, 0, z, 32'h2, 0};
      vt[8]  = '{0, 32'h1C, 32'h0, 0, z, 32'h3, 0};
      vt[9]  = '{1, 32'h20, 32'h0, 0, z, 32'h0, 0};
      vt[10] = '{0, 32'h04, 32'h0, 0, z, 32'h0001_0000, 0};
      vt[11] = '{0, 32'h40, 32'h0, 0, z, 32'h0, 1};
      vt[12] = '{1, 32'h04, 32'h0, 0, z, 32'h0, 1};
      vt[13] = '{0, 32'h00, 32'h0, 0, z, 32'h1, 0};
      vt[14] = '{1, 32'h0C, 32'h0, 0, z, 32'h0, 1};
      vt[15] = '{0, 32'h08, 32'h0, 0, z, 32'h0, 0};

      // Reset
      rst_n = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_irq", 32'(irq), 0);
      rst_n = 1;
      @(posedge clk); #1;

      for (int i = 0; i < 16; i++) begin
         do_cycle(1, vt[i].we, vt[i].addr, vt[i].wdata, 4'hF, vt[i].tv, vt[i].rec);
         chk($sformatf("tbl%0d_rvalid", i), 32'(s_rvalid), 1);
         if (!vt[i].we) chk($sformatf("tbl%0d_rdata", i), s_rdata, vt[i].exp_rdata);
         chk($sformatf("tbl%0d_err", i), 32'(s_err), 32'(vt[i].exp_err));
      end

      // Overfill: 18 pushes into 16 entries
      for (int i = 0; i < 18; i++) push(mk_rec(7'(8'h10 + i), 32'h100 + i, 32'h200 + i, 32'h300 + i));
      rd(32'h04); chk("full_status", s_rdata, 32'h0006_0010);
      rd(32'h0C); chk("full_drops", s_rdata, 32'd2);
      rd(32'h10); chk("full_head_op", s_rdata, 32'h10);
      rd(32'h14); chk("full_head_a", s_rdata, 32'h100);

      // Full FIFO: push and POP in the same cycle
      nr = mk_rec(7'h7F, 32'hAAAA_5555, 32'h1234, 32'hDEAD);
      do_cycle(1, 1, 32'h20, 32'h0, 4'hF, 1, nr);
      rd(32'h04); chk("pp_status", s_rdata, 32'h0006_0010);
      rd(32'h0C); chk("pp_drops", s_rdata, 32'd2);
      rd(32'h10); chk("pp_head_op", s_rdata, 32'h11);
      for (int i = 0; i < 15; i++) wr(32'h20, 32'h0);
      rd(32'h10); chk("tail_op", s_rdata, 32'h7F);
      rd(32'h14); chk("tail_a", s_rdata, 32'hAAAA_5555);
      rd(32'h1C); chk("tail_r", s_rdata, 32'hDEAD);
      wr(32'h20, 32'h0);
      rd(32'h04); chk("drained_status", s_rdata, 32'h0005_0000);

      // CLEAR with a concurrent push
      for (int i = 0; i < 17; i++) push(mk_rec(7'(i), i, i, i));
      rd(32'h0C); chk("pre_clr_drops", s_rdata, 32'd3);
      do_cycle(1, 1, 32'h00, 32'h5, 4'hF, 1, mk_rec(7'h2A, 9, 9, 9));
      rd(32'h04); chk("clr_status", s_rdata, 32'h0001_0000);
      rd(32'h0C); chk("clr_drops", s_rdata, 32'd0);
      rd(32'h00); chk("clr_ctrl", s_rdata, 32'd1);

      // Threshold interrupt
      wr(32'h08, 32'd4);
      wr(32'h00, 32'h3);
      for (int i = 0; i < 3; i++) begin
         push(mk_rec(7'(i), i, i, i));
         chk($sformatf("irq_low%0d", i), 32'(s_irq), 0);
      end
      push(mk_rec(7'h3, 3, 3, 3));
      chk("irq_rise", 32'(s_irq), 1);
      wr(32'h20, 32'h0);
      chk("irq_fall", 32'(s_irq), 0);
      push(mk_rec(7'h4, 4, 4, 4));
      chk("irq_rise2", 32'(s_irq), 1);

      // Asynchronous reset mid-drain
      #2 rst_n = 0;
      #1;
      chk("arst_irq", 32'(irq), 0);
      chk("arst_rvalid", 32'(rvalid), 0);
      @(posedge clk); #1;
      rst_n = 1;
      model_reset();
      rd(32'h04); chk("arst_status", s_rdata, 32'h0001_0000);
      rd(32'h10); chk("arst_head", s_rdata, 32'd0);
      rd(32'h00); chk("arst_ctrl", s_rdata, 32'd0);
      rd(32'h08); chk("arst_thresh", s_rdata, 32'd0);

      // Randomized traffic against the reference model
      offs = '{10'h000, 10'h004, 10'h008, 10'h00C, 10'h010,
               10'h014, 10'h018, 10'h01C, 10'h020, 10'h040};
      for (int i = 0; i < 3000; i++) begin
         bit          rq, w, tv, drain;
         int          k;
         logic [9:0]  off;
         logic [7:0]  widx;
         logic [31:0] ad, wd;
         logic [3:0]  bb;
         rec_t        rc;
         drain = ((i / 200) % 2) == 1;
         rq = $urandom_range(0, 1) == 1;
         k  = $urandom_range(0, 9);
         if (drain && $urandom_range(0, 1) == 1) begin rq = 1; k = 8; end
         off = offs[k];
         if (k == 9 && $urandom_range(0, 1) == 1) off = 10'($urandom_range(0, 1023));
         widx = off[9:2];
         w = $urandom_range(0, 1) == 1;
         if (widx == 8'h08) w = 1;
         ad = ($urandom() & 32'hFFFF_FC00) | {22'd0, off};
         bb = 4'hF;
         if (!w) bb = 4'($urandom_range(0, 15));
         else if ((widx == 8'h00 || widx == 8'h02 || widx == 8'h08) && $urandom_range(0, 7) == 0)
            bb = 4'($urandom_range(0, 14));
         wd = $urandom();
         if (widx == 8'h00)
            wd = {29'd0, ($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0)};
         else if (widx == 8'h02)
            wd = 32'($urandom_range(0, DEPTH + 2));
         tv = drain ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         rc = mk_rec(7'($urandom_range(0, 127)), $urandom(), $urandom(), $urandom());
         do_cycle(rq, w, ad, wd, bb, tv, rc);
         model_check("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
